kzg_sweep_ctrl: RTL and testbench

Sequencer that sweeps one origin point against a table of up to 2^ADDR_W normalized center points through the K_ZGu gradient pipeline, one point per cycle. It reads centers from an external synchronous-read point memory, drives the K_ZGu operand ports, tracks in-flight points with a valid shift register matched to the pipeline latency, and accumulates the returned K_ZGx/y/z terms into three wide signed sums. It sits between the gradient-evaluation top level, which issues `start`, and one K_ZGu instance.

---
 rtl/kzg_sweep_ctrl_if.sv | 55 +++++
 rtl/kzg_sweep_ctrl.sv | 168 ++++++++++++++++
 tb/tb_kzg_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kzg_sweep_ctrl_if.sv
// Bundle of the start/result handshake, point-memory read port and K_ZGu operand/result
// signals between the gradient top level, the sweep controller and its K_ZGu instance.
interface kzg_sweep_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned ACC_W      = 48
);
    logic                         start;
    logic [ADDR_W:0]              n_pts;
    logic signed [DATA_WIDTH-1:0] ori_x;
    logic signed [DATA_WIDTH-1:0] ori_y;
    logic signed [DATA_WIDTH-1:0] ori_z;

    logic                         mem_en;
    logic [ADDR_W-1:0]            mem_addr;
    logic signed [DATA_WIDTH-1:0] mem_x;
    logic signed [DATA_WIDTH-1:0] mem_y;
    logic signed [DATA_WIDTH-1:0] mem_z;

    logic signed [DATA_WIDTH-1:0] kzg_ori_x;
    logic signed [DATA_WIDTH-1:0] kzg_ori_y;
    logic signed [DATA_WIDTH-1:0] kzg_ori_z;
    logic signed [DATA_WIDTH-1:0] kzg_norm_x;
    logic signed [DATA_WIDTH-1:0] kzg_norm_y;
    logic signed [DATA_WIDTH-1:0] kzg_norm_z;
    logic signed [31:0]           kzg_x;
    logic signed [31:0]           kzg_y;
    logic signed [31:0]           kzg_z;

    logic                         busy;
    logic                         done;
    logic signed [ACC_W-1:0]      sum_x;
    logic signed [ACC_W-1:0]      sum_y;
    logic signed [ACC_W-1:0]      sum_z;

    modport slave (
        input  start, n_pts, ori_x, ori_y, ori_z,
        input  mem_x, mem_y, mem_z,
        input  kzg_x, kzg_y, kzg_z,
        output mem_en, mem_addr,
        output kzg_ori_x, kzg_ori_y, kzg_ori_z,
        output kzg_norm_x, kzg_norm_y, kzg_norm_z,
        output busy, done, sum_x, sum_y, sum_z
    );

    modport master (
        output start, n_pts, ori_x, ori_y, ori_z,
        output mem_x, mem_y, mem_z,
        output kzg_x, kzg_y, kzg_z,
        input  mem_en, mem_addr,
        input  kzg_ori_x, kzg_ori_y, kzg_ori_z,
        input  kzg_norm_x, kzg_norm_y, kzg_norm_z,
        input  busy, done, sum_x, sum_y, sum_z
    );
endinterface

// File: rtl/kzg_sweep_ctrl.sv
// Sweeps one origin against n_pts memory-resident centers through K_ZGu, one point per
// cycle, and accumulates the returned K_ZGx/y/z terms into wide wrapping signed sums.
module kzg_sweep_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned KZG_LAT    = 22,
    parameter int unsigned ACC_W      = 48
) (
    input logic             clk,
    input logic             rst,
    kzg_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e                       state_q, state_d;
    logic [ADDR_W-1:0]            last_addr_q, last_addr_d;
    logic                         mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic signed [DATA_WIDTH-1:0] ori_x_q, ori_x_d;
    logic signed [DATA_WIDTH-1:0] ori_y_q, ori_y_d;
    logic signed [DATA_WIDTH-1:0] ori_z_q, ori_z_d;

    logic                         rd_vld_q;
    logic [KZG_LAT-1:0]           vld_sr_q;
    logic [KZG_LAT-1:0]           vld_older;
    logic                         res_vld;
    logic                         pipe_busy;
    logic                         clr_sums;

    logic signed [ACC_W-1:0]      sum_x_q, sum_x_d;
    logic signed [ACC_W-1:0]      sum_y_q, sum_y_d;
    logic signed [ACC_W-1:0]      sum_z_q, sum_z_d;

    assign res_vld = vld_sr_q[KZG_LAT-1];

    // The result arriving this cycle is accumulated on the same edge that leaves DRAIN,
    // so only entries behind the head of the valid pipe keep the sweep draining.
    always_comb begin
        vld_older              = vld_sr_q;
        vld_older[KZG_LAT-1]   = 1'b0;
        pipe_busy              = rd_vld_q | (|vld_older);
    end

    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        last_addr_d = last_addr_q;
        ori_x_d     = ori_x_q;
        ori_y_d     = ori_y_q;
        ori_z_d     = ori_z_q;
        clr_sums    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // n_pts = 2^ADDR_W truncates to 0, whose minus-one is the top address.
                    last_addr_d = bus.n_pts[ADDR_W-1:0] - ADDR_ONE;
                    ori_x_d     = bus.ori_x;
                    ori_y_d     = bus.ori_y;
                    ori_z_d     = bus.ori_z;
                    mem_addr_d  = '0;
                    clr_sums    = 1'b1;
                    if (bus.n_pts != '0) begin
                        state_d  = ST_ISSUE;
                        mem_en_d = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_addr_q == last_addr_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_comb begin
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        sum_z_d = sum_z_q;
        if (clr_sums) begin
            sum_x_d = '0;
            sum_y_d = '0;
            sum_z_d = '0;
        end else if (res_vld) begin
            sum_x_d = sum_x_q + {{(ACC_W-32){bus.kzg_x[31]}}, bus.kzg_x};
            sum_y_d = sum_y_q + {{(ACC_W-32){bus.kzg_y[31]}}, bus.kzg_y};
            sum_z_d = sum_z_q + {{(ACC_W-32){bus.kzg_z[31]}}, bus.kzg_z};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_addr_q <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ori_x_q     <= '0;
            ori_y_q     <= '0;
            ori_z_q     <= '0;
            rd_vld_q    <= 1'b0;
            vld_sr_q    <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            sum_z_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ori_x_q     <= ori_x_d;
            ori_y_q     <= ori_y_d;
            ori_z_q     <= ori_z_d;
            rd_vld_q    <= mem_en_q;
            vld_sr_q    <= (vld_sr_q << 1) | KZG_LAT'(rd_vld_q);
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            sum_z_q     <= sum_z_d;
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.kzg_ori_x  = ori_x_q;
    assign bus.kzg_ori_y  = ori_y_q;
    assign bus.kzg_ori_z  = ori_z_q;
    assign bus.kzg_norm_x = bus.mem_x;
    assign bus.kzg_norm_y = bus.mem_y;
    assign bus.kzg_norm_z = bus.mem_z;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sum_x      = sum_x_q;
    assign bus.sum_y      = sum_y_q;
    assign bus.sum_z      = sum_z_q;
endmodule

// File: tb/tb_kzg_sweep_ctrl.sv
// Randomized bench for kzg_sweep_ctrl: point memory and K_ZGu delay-line models around
// the DUT, sums and timing predicted from the sweep rules.
module tb_kzg_sweep_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int LAT   = 22;
    localparam int ACCW  = 48;
    localparam int NMAX  = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   force_max = 1'b0;

    logic signed [DW-1:0] mx [NMAX];
    logic signed [DW-1:0] my [NMAX];
    logic signed [DW-1:0] mz [NMAX];
    logic signed [31:0]   px [LAT];
    logic signed [31:0]   py [LAT];
    logic signed [31:0]   pz [LAT];

    kzg_sweep_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .ACC_W(ACCW)) bus ();

    kzg_sweep_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_W     (AW),
        .KZG_LAT    (LAT),
        .ACC_W      (ACCW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read point memory.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_x <= mx[bus.mem_addr];
            bus.mem_y <= my[bus.mem_addr];
            bus.mem_z <= mz[bus.mem_addr];
        end
    end

    // K_ZGu stand-in: LAT-deep delay of (x, 2y, -z), or a constant maximum term.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
            pz[i] <= pz[i-1];
        end
        if (force_max) begin
            px[0] <= 32'h7FFF_FFFF;
            py[0] <= 32'h7FFF_FFFF;
            pz[0] <= 32'h7FFF_FFFF;
        end else begin
            px[0] <= 32'(bus.kzg_norm_x);
            py[0] <= 32'(bus.kzg_norm_y) * 2;
            pz[0] <= -32'(bus.kzg_norm_z);
        end
    end
    assign bus.kzg_x = px[LAT-1];
    assign bus.kzg_y = py[LAT-1];
    assign bus.kzg_z = pz[LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] s48(input longint v);
        logic [47:0] t;
        t = v[47:0];
        return {16'h0, t};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NMAX; i++) begin
            mx[i] = DW'($urandom);
            my[i] = DW'($urandom);
            mz[i] = DW'($urandom);
        end
    endtask

    // Entered and left at a falling edge; start is sampled on the next rising edge.
    task automatic run_sweep(input string tag, input int n, input int rep_a, input int rep_b);
        longint ex, ey, ez;
        int     exp_done, exp_busy, done_cyc, addr_cnt, busy_cnt, last_addr;
        bit     addr_ok, busy_ok;
        logic [DW-1:0] ox, oy, oz;

        ex = 0; ey = 0; ez = 0;
        for (int i = 0; i < n; i++) begin
            if (force_max) begin
                ex += 2147483647; ey += 2147483647; ez += 2147483647;
            end else begin
                ex += longint'(mx[i]);
                ey += 2 * longint'(my[i]);
                ez -= longint'(mz[i]);
            end
        end
        exp_done = (n == 0) ? 1 : n + 2 + LAT;
        exp_busy = (n == 0) ? 0 : n + 1 + LAT;

        ox = DW'($urandom); oy = DW'($urandom); oz = DW'($urandom);
        bus.start = 1'b1;
        bus.n_pts = (AW+1)'(n);
        bus.ori_x = ox; bus.ori_y = oy; bus.ori_z = oz;
        @(posedge clk);

        done_cyc = -1; addr_cnt = 0; busy_cnt = 0; last_addr = -1;
        addr_ok = 1'b1; busy_ok = 1'b1;
        for (int cyc = 1; cyc <= n + LAT + 10; cyc++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                if (bus.mem_addr != AW'(addr_cnt) || cyc != addr_cnt + 1) addr_ok = 1'b0;
                last_addr = int'(bus.mem_addr);
                addr_cnt++;
            end
            if (bus.busy) begin
                busy_cnt++;
                if (cyc > exp_busy) busy_ok = 1'b0;
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            bus.start = (cyc == rep_a) || (cyc == rep_b);
            if (bus.start) begin
                bus.n_pts = (AW+1)'($urandom_range(0, NMAX));
                bus.ori_x = DW'($urandom); bus.ori_y = DW'($urandom); bus.ori_z = DW'($urandom);
            end
        end
        bus.start = 1'b0;

        check_eq({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check_eq({tag, "_sum_x"}, {16'h0, bus.sum_x}, s48(ex));
        check_eq({tag, "_sum_y"}, {16'h0, bus.sum_y}, s48(ey));
        check_eq({tag, "_sum_z"}, {16'h0, bus.sum_z}, s48(ez));
        check_eq({tag, "_ori"}, {16'h0, bus.kzg_ori_x, bus.kzg_ori_y, bus.kzg_ori_z},
                 {16'h0, ox, oy, oz});
        check_eq({tag, "_reads"}, 64'(addr_cnt), 64'(n));
        check_eq({tag, "_addr_seq_ok"}, 64'(addr_ok), 64'd1);
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check_eq({tag, "_busy_window_ok"}, 64'(busy_ok), 64'd1);
        if (n > 0) check_eq({tag, "_last_addr"}, 64'(last_addr), 64'(n - 1));

        @(negedge clk);
        check_eq({tag, "_done_pulse_end"}, 64'(bus.done), 64'd0);
        check_eq({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_sum_x_hold"}, {16'h0, bus.sum_x}, s48(ex));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.n_pts = '0;
        bus.ori_x = '0; bus.ori_y = '0; bus.ori_z = '0;
        fill_random();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_mem_en", 64'(bus.mem_en), 64'd0);
        check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check_eq("rst_sums", {16'h0, bus.sum_x | bus.sum_y | bus.sum_z}, 64'd0);
        check_eq("rst_ori", {16'h0, bus.kzg_ori_x, bus.kzg_ori_y, bus.kzg_ori_z}, 64'd0);

        // Directed four-point sweep.
        for (int i = 0; i < 4; i++) begin
            mx[i] = DW'(i + 1); my[i] = 16'sd10; mz[i] = 16'sd5;
        end
        run_sweep("dir4", 4, 0, 0);
        check_eq("dir4_lit_x", {16'h0, bus.sum_x}, s48(10));
        check_eq("dir4_lit_y", {16'h0, bus.sum_y}, s48(80));
        check_eq("dir4_lit_z", {16'h0, bus.sum_z}, s48(-20));

        // Empty sweep clears previous sums.
        run_sweep("n0", 0, 0, 0);

        // Full table with maximum positive terms.
        fill_random();
        force_max = 1'b1;
        run_sweep("full", NMAX, 0, 0);
        force_max = 1'b0;
        check_eq("full_lit_x", {16'h0, bus.sum_x}, s48(longint'(NMAX) * 2147483647));

        // Reset in the middle of an N=8 sweep, then a single-point sweep.
        fill_random();
        bus.start = 1'b1;
        bus.n_pts = (AW+1)'(8);
        @(posedge clk);
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == 9)  rst = 1'b1;
            if (cyc == 10) rst = 1'b0;
            if (cyc == 11) begin
                check_eq("mrst_busy", 64'(bus.busy), 64'd0);
                check_eq("mrst_mem_en", 64'(bus.mem_en), 64'd0);
                check_eq("mrst_sums", {16'h0, bus.sum_x | bus.sum_y | bus.sum_z}, 64'd0);
            end
        end
        run_sweep("after_rst", 1, 0, 0);

        // Extra start pulses during ISSUE and DRAIN.
        fill_random();
        run_sweep("restart", 6, 3, 15);

        // Back-to-back sweeps; the second yields negative sums.
        fill_random();
        run_sweep("b2b_a", 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            mx[i] = -16'sd1; my[i] = -16'sd1; mz[i] = 16'sd1;
        end
        run_sweep("b2b_b", 3, 0, 0);
        check_eq("b2b_lit_x", {16'h0, bus.sum_x}, s48(-3));
        check_eq("b2b_lit_y", {16'h0, bus.sum_y}, s48(-6));
        check_eq("b2b_lit_z", {16'h0, bus.sum_z}, s48(-3));

        // Random sweeps.
        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_sweep($sformatf("rnd%0d", k), int'($urandom_range(1, 40)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
